// File: rtl/fft_mag_packer.sv
// FFT bin magnitude packer: max+min/2 magnitude, FIFO buffer, MSB-first byte serializer.
// Define FFT_SYNC_HEADER_EN to prefix frame-start words with SYNC_BYTE0/SYNC_BYTE1.
module fft_mag_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  SYNC_BYTE0 = 8'hA5,
    parameter logic [7:0]  SYNC_BYTE1 = 8'h5A
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   fft_re,
    input  logic [31:0]                   fft_im,
    input  logic                          fft_valid,
    input  logic [15:0]                   fft_index,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

`ifdef FFT_SYNC_HEADER_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StSync0,
        StSync1,
        StB3,
        StB2,
        StB1,
        StB0
    } state_t;

    // Two's-complement magnitude; 32'h8000_0000 maps to itself, which is exact as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Stage 1: operand magnitudes and frame-start flag
    logic        s1_valid;
    logic        s1_sof;
    logic [31:0] s1_a;
    logic [31:0] s1_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_a     <= 32'd0;
            s1_b     <= 32'd0;
        end else begin
            s1_valid <= fft_valid;
            if (fft_valid) begin
                s1_sof <= (fft_index == 16'd0);
                s1_a   <= abs32(fft_re);
                s1_b   <= abs32(fft_im);
            end
        end
    end

    // Stage 2: mag = max + min/2, bounded by 3*2^30 so 32 bits suffice
    logic [31:0] s1_max;
    logic [31:0] s1_min;
    logic [31:0] mag_d;
    logic        s2_valid;
    logic        s2_sof;
    logic [31:0] s2_mag;

    always_comb begin
        s1_max = (s1_a >= s1_b) ? s1_a : s1_b;
        s1_min = (s1_a >= s1_b) ? s1_b : s1_a;
        mag_d  = s1_max + (s1_min >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_mag   <= 32'd0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sof <= s1_sof;
                s2_mag <= mag_d;
            end
        end
    end

    // FIFO of {sof, mag}
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic [32:0]   rd_word;

    always_comb begin
        full    = (count == LW'(FIFO_DEPTH));
        empty   = (count == '0);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
        push    = s2_valid && (!full || pop);
        drop    = s2_valid && full && !pop;
        rd_word = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s2_sof, s2_mag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign fifo_level = count;

    // Serializer
    state_t      state_q;
    state_t      state_d;
    state_t      first_st;
    logic [31:0] hold_q;
    logic [31:0] hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        pop      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        first_st = (SYNC_EN && rd_word[32]) ? StSync0 : StB3;
        unique case (state_q)
            StIdle: begin
                tx_valid = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = first_st;
                end
            end
            StSync0: begin
                tx_data = SYNC_BYTE0;
                if (tx_ready) state_d = StSync1;
            end
            StSync1: begin
                tx_data = SYNC_BYTE1;
                if (tx_ready) state_d = StB3;
            end
            StB3: begin
                tx_data = hold_q[31:24];
                if (tx_ready) state_d = StB2;
            end
            StB2: begin
                tx_data = hold_q[23:16];
                if (tx_ready) state_d = StB1;
            end
            StB1: begin
                tx_data = hold_q[15:8];
                if (tx_ready) state_d = StB0;
            end
            StB0: begin
                tx_data = hold_q[7:0];
                if (tx_ready) begin
                    // Chain straight into the next word to avoid an idle gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = first_st;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                tx_valid = 1'b0;
                state_d  = StIdle;
            end
        endcase
        if (pop) begin
            hold_d = rd_word[31:0];
        end
    end

endmodule

// File: tb/tb_fft_mag_packer.sv
// Bench for fft_mag_packer: arithmetic magnitude model feeding an expected-byte queue,
// checked on every accepted byte, plus literal byte sequences and timing points.
module tb_fft_mag_packer;

    localparam int unsigned FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] fft_re = '0;
    logic [31:0] fft_im = '0;
    logic        fft_valid = 1'b0;
    logic [15:0] fft_index = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    fft_mag_packer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_BYTE0 (8'hA5),
        .SYNC_BYTE1 (8'h5A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fft_re     (fft_re),
        .fft_im     (fft_im),
        .fft_valid  (fft_valid),
        .fft_index  (fft_index),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_mag(input logic [31:0] re, input logic [31:0] im);
        longint a;
        longint b;
        longint mx;
        longint mn;
        a  = longint'($signed(re));
        b  = longint'($signed(im));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return 32'(mx + mn / 2);
    endfunction

    task automatic push_model(input logic [31:0] re, input logic [31:0] im,
                              input logic [15:0] idx);
        logic [31:0] m;
        m = model_mag(re, im);
`ifdef FFT_SYNC_HEADER_EN
        if (idx == 16'd0) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5A);
        end
`else
        if (idx == 16'd0) m = m;
`endif
        for (int k = 3; k >= 0; k--) exp_q.push_back(m[8*k +: 8]);
    endtask

    task automatic drive(input logic [31:0] re, input logic [31:0] im,
                         input logic [15:0] idx, input bit keep);
        fft_re    = re;
        fft_im    = im;
        fft_index = idx;
        fft_valid = 1'b1;
        if (keep) push_model(re, im, idx);
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || tx_valid) && cyc < 3000) begin
            @(posedge clk);
            #1;
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string name, input logic [63:0] bytes, input int n);
        logic [31:0] act;
        chk({name, "_len"}, got_q.size(), n);
        for (int k = 0; k < n; k++) begin
            act = (k < got_q.size()) ? {24'd0, got_q[k]} : 32'hFFFF_FFFF;
            chk(name, act, {24'd0, bytes[8*(n-1-k) +: 8]});
        end
        got_q.delete();
    endtask

    // Per-cycle compare: accepted bytes against the model, and hold stability during stalls.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h, required none", tx_data);
                end else begin
                    chk("tx_byte", tx_data, exp_q.pop_front());
                end
                got_q.push_back(tx_data);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Latency: tx_valid rises on the third edge after the sampling edge
        fft_re = 32'd3; fft_im = 32'hFFFF_FFFC; fft_index = 16'd5; fft_valid = 1'b1;
        push_model(32'd3, 32'hFFFF_FFFC, 16'd5);
        @(posedge clk); #1; fft_valid = 1'b0;
        chk("lat_e0", tx_valid, 0);
        @(posedge clk); #1; chk("lat_e1", tx_valid, 0);
        @(posedge clk); #1; chk("lat_e2", tx_valid, 0);
        @(posedge clk); #1; chk("lat_e3", tx_valid, 1);
        drain(0);
        check_got("w_3_m4", 64'h0000_0005, 4);

        drive(32'h8000_0000, 32'h8000_0000, 16'd1, 1);
        drain(0);
        check_got("w_minint", 64'hC000_0000, 4);
        drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'd2, 1);
        drain(0);
        check_got("w_maxint", 64'hBFFF_FFFE, 4);

        drive(32'd1, 32'd0, 16'd0, 1);
        drain(0);
`ifdef FFT_SYNC_HEADER_EN
        check_got("w_sof", 64'hA55A_0000_0001, 6);
`else
        check_got("w_sof", 64'h0000_0001, 4);
`endif

        // Random backpressure: same bytes as with tx_ready held high
        drive(32'h1234_5678, 32'd0, 16'd3, 1);
        drive(32'hFFFF_FF9C, 32'd300, 16'd9, 1);
        drain(1);
        tx_ready = 1'b1;
        check_got("w_rand", 64'h1234_5678_0000_015E, 8);

        // Overflow: the first word is held, FIFO_DEPTH more fit, the last two drop
        tx_ready = 1'b0;
        for (int i = 1; i <= FIFO_DEPTH + 3; i++) begin
            drive(32'(i) * 32'd1000, -32'(i), 16'(i), i <= FIFO_DEPTH + 1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("ovf_level", fifo_level, FIFO_DEPTH);
        chk("ovf_flag", overflow, 1);
        tx_ready = 1'b1;
        drain(0);
        chk("ovf_bytes", got_q.size(), (FIFO_DEPTH + 1) * 4);
        got_q.delete();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_level_empty", fifo_level, 0);

        // Asynchronous reset in the middle of a word
        tx_ready = 1'b0;
        drive(32'h0102_0304, 32'd0, 16'd7, 1);
        drive(32'h0000_0777, 32'd0, 16'd8, 1);
        cyc = 0;
        while (!tx_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk("mid_valid", tx_valid, 1);
        chk("mid_level", fifo_level, 1);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        chk("mid_b1", tx_data, 8'h03);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_tx_data", tx_data, 0);
        got_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        drive(32'hFFFF_FFFB, 32'hFFFF_EDCC, 16'd4, 1);
        drain(0);
        check_got("post_rst", 64'h0000_1236, 4);
        chk("post_rst_overflow", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
